// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute-stage ALU and the blocks that borrow it.
//   - ALU opcode encodings (4-bit Operation field)
//   - mul_state_t : state encoding of the iterative shift-add multiplier FSM
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_XOR  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_ADD  = 4'b0100;
    localparam logic [3:0] ALU_BGE  = 4'b0101;
    localparam logic [3:0] ALU_BNE  = 4'b0110;
    localparam logic [3:0] ALU_SRAI = 4'b0111;
    localparam logic [3:0] ALU_EQ   = 4'b1000;
    localparam logic [3:0] ALU_SLLI = 4'b1001;
    localparam logic [3:0] ALU_LUI  = 4'b1010;
    localparam logic [3:0] ALU_BLT  = 4'b1101;
    localparam logic [3:0] ALU_SRLI = 4'b1100;
    localparam logic [3:0] ALU_SLT  = 4'b1110;
    localparam logic [3:0] ALU_JALR = 4'b1111;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADD  = 3'd1,
        SHL  = 3'd2,
        SHR  = 3'd3,
        DONE = 3'd4
    } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// ----------------------------------------------------------------------------
// alu_mul_seq
// Iterative shift-add multiplier that borrows the shared execute-stage ALU.
// Each iteration issues three ALU operations on consecutive cycles:
//   ADD  : acc    <- acc + (mplier[0] ? mcand : 0)
//   SHL  : mcand  <- mcand << 1
//   SHR  : mplier <- mplier >> 1   (loop ends when this becomes 0)
// Only the low DATA_WIDTH bits of the product are produced.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   start      in   multiply request, sampled only while idle
//   op_a       in   multiplicand, captured on accepted start
//   op_b       in   multiplier, captured on accepted start
//   busy       out  high in every non-idle state
//   done       out  one-cycle pulse, product valid in the same cycle
//   product    out  low word of op_a*op_b, held until next accepted start
//   alu_req    out  high while this block owns the ALU (ADD/SHL/SHR)
//   alu_op     out  ALU Operation
//   alu_src_a  out  ALU SrcA
//   alu_src_b  out  ALU SrcB
//   alu_result in   ALU ALUResult (combinational, same cycle)
// ----------------------------------------------------------------------------
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [DATA_WIDTH-1:0]    op_a,
    input  logic [DATA_WIDTH-1:0]    op_b,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    product,
    output logic                     alu_req,
    output logic [OPCODE_LENGTH-1:0] alu_op,
    output logic [DATA_WIDTH-1:0]    alu_src_a,
    output logic [DATA_WIDTH-1:0]    alu_src_b,
    input  logic [DATA_WIDTH-1:0]    alu_result
);

    mul_state_t              r_state;
    mul_state_t              w_state_next;
    logic [DATA_WIDTH-1:0]   r_acc;
    logic [DATA_WIDTH-1:0]   r_mcand;
    logic [DATA_WIDTH-1:0]   r_mplier;
    logic [DATA_WIDTH-1:0]   r_product;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_product <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc    <= '0;
                        r_mcand  <= op_a;
                        r_mplier <= op_b;
                    end
                end
                ADD:  r_acc     <= alu_result;
                SHL:  r_mcand   <= alu_result;
                SHR:  r_mplier  <= alu_result;
                DONE: r_product <= r_acc;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs. When the ALU is not owned, drive a harmless
    // ADD 0+0 so the shared mux never sees X or stale operands.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != IDLE);
        done         = 1'b0;
        alu_req      = 1'b0;
        alu_op       = OPCODE_LENGTH'(ALU_ADD);
        alu_src_a    = '0;
        alu_src_b    = '0;
        // The registered copy only updates at the end of DONE, so bypass
        // acc during DONE to make product valid alongside the done pulse.
        product      = r_product;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = (op_b != '0) ? ADD : DONE;
                end
            end
            ADD: begin
                alu_req      = 1'b1;
                alu_op       = OPCODE_LENGTH'(ALU_ADD);
                alu_src_a    = r_acc;
                alu_src_b    = r_mplier[0] ? r_mcand : '0;
                w_state_next = SHL;
            end
            SHL: begin
                alu_req      = 1'b1;
                alu_op       = OPCODE_LENGTH'(ALU_SLLI);
                alu_src_a    = r_mcand;
                alu_src_b    = DATA_WIDTH'(1);
                w_state_next = SHR;
            end
            SHR: begin
                alu_req      = 1'b1;
                alu_op       = OPCODE_LENGTH'(ALU_SRLI);
                alu_src_a    = r_mplier;
                alu_src_b    = DATA_WIDTH'(1);
                // Once the remaining multiplier bits are all zero, further
                // iterations would only add zero, so finish early.
                w_state_next = (alu_result == '0) ? DONE : ADD;
            end
            DONE: begin
                done         = 1'b1;
                product      = r_acc;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

endmodule
